// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory port of dmem_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if;
  logic        m0_req,    m1_req;
  logic        m0_we,     m1_we;
  logic [1:0]  m0_size,   m1_size;
  logic        m0_uns,    m1_uns;
  logic [31:0] m0_addr,   m1_addr;
  logic [31:0] m0_wdata,  m1_wdata;
  logic        m0_gnt,    m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata,  m1_rdata;
  logic        m0_err,    m1_err;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_size, m0_uns, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_size, m1_uns, m1_addr, m1_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_size, m0_uns, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_size, m1_uns, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter for the data memory: grant / access / response
// sequencing, byte-lane strobes, write-data replication and load alignment/extension.
module dmem_arbiter #(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input logic         clk,
    input logic         rst_n,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        last_q;
    logic        id_q, we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata0_q, rdata1_q;

    logic        grant, sel;
    logic        s_we, s_uns, s_err;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;

    logic        access_ok;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] shifted;
    logic [31:0] load_res;

    // gnt is gated by rst_n so every output reads 0 while reset is held
    always_comb begin
        grant = 1'b0;
        sel   = 1'b0;
        if (state == IDLE && rst_n) begin
            if (bus.m0_req && bus.m1_req) begin
                grant = 1'b1;
                sel   = ~last_q;
            end else if (bus.m0_req) begin
                grant = 1'b1;
                sel   = 1'b0;
            end else if (bus.m1_req) begin
                grant = 1'b1;
                sel   = 1'b1;
            end
        end
    end

    always_comb begin
        s_we    = sel ? bus.m1_we    : bus.m0_we;
        s_size  = sel ? bus.m1_size  : bus.m0_size;
        s_uns   = sel ? bus.m1_uns   : bus.m0_uns;
        s_addr  = sel ? bus.m1_addr  : bus.m0_addr;
        s_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
        s_err   = 1'b0;
        if (s_size == 2'b11)                         s_err = 1'b1;
        if (s_size == 2'b01 && s_addr[0])            s_err = 1'b1;
        if (s_size == 2'b10 && s_addr[1:0] != 2'b00) s_err = 1'b1;
        if (s_addr[31:2] >= 30'(DEPTH_WORDS))        s_err = 1'b1;
    end

    assign bus.m0_gnt = grant & ~sel;
    assign bus.m1_gnt = grant &  sel;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last_q <= 1'b1;
        end else begin
            state <= state_nxt;
            if (grant) last_q <= sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            id_q    <= sel;
            we_q    <= s_we;
            uns_q   <= s_uns;
            err_q   <= s_err;
            size_q  <= s_size;
            addr_q  <= s_addr;
            wdata_q <= s_wdata;
        end
    end

    assign access_ok = (state == ACCESS) && !err_q;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = '0;
        case (size_q)
            2'b00: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = '0;
            end
        endcase
    end

    assign bus.mem_en    = access_ok;
    assign bus.mem_we    = access_ok & we_q;
    assign bus.mem_be    = (access_ok && we_q) ? be : 4'b0000;
    assign bus.mem_addr  = access_ok ? {addr_q[31:2], 2'b00} : '0;
    assign bus.mem_wdata = (access_ok && we_q) ? wdata_rep : '0;

    always_comb begin
        shifted  = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        load_res = '0;
        if (access_ok && !we_q) begin
            case (size_q)
                2'b00:   load_res = uns_q ? {24'h000000, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
                2'b01:   load_res = uns_q ? {16'h0000, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
                default: load_res = bus.mem_rdata;
            endcase
        end
    end

    // Result is latched at the end of ACCESS so it is already valid during RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state == ACCESS) begin
            if (id_q) rdata1_q <= load_res;
            else      rdata0_q <= load_res;
        end
    end

    assign bus.m0_rvalid = (state == RESP) && !id_q;
    assign bus.m1_rvalid = (state == RESP) &&  id_q;
    assign bus.m0_err    = bus.m0_rvalid & err_q;
    assign bus.m1_err    = bus.m1_rvalid & err_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected responses are queued at grant time
// from a reference memory and compared when rvalid is seen.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.DEPTH_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int unsigned i);
    return (i * 32'h01010101) ^ 32'hC3A50F00;
  endfunction

  logic [31:0] mem [256];
  logic [31:0] refm [256];

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 256; i++) mem[i] <= pat(i);
    end else if (bus.mem_en && bus.mem_we) begin
      for (int unsigned b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  function automatic bit exp_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
           (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'h400);
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [1:0] o);
    case (size)
      2'b00: case (o) 2'd0: return 4'b0001; 2'd1: return 4'b0010;
                      2'd2: return 4'b0100; default: return 4'b1000; endcase
      2'b01: return o[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00: return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01: return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] size,
                                           input bit uns, input logic [1:0] o);
    logic [7:0] b;
    logic [15:0] h;
    case (o)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = o[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  typedef struct {
    bit          id;
    logic [31:0] rdata;
    bit          err;
  } exp_t;
  exp_t sbq[$];

  task automatic push_exp(input bit id, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    logic [3:0] be;
    logic [31:0] wd;
    e.id = id;
    e.err = exp_err(size, addr);
    e.rdata = '0;
    if (!e.err && we) begin
      be = exp_be(size, addr[1:0]);
      wd = exp_wd(size, wdata);
      for (int b = 0; b < 4; b++)
        if (be[b]) refm[addr[9:2]][8*b +: 8] = wd[8*b +: 8];
    end else if (!e.err) begin
      e.rdata = exp_load(refm[addr[9:2]], size, uns, addr[1:0]);
    end
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (bus.m0_rvalid || bus.m1_rvalid)) begin
      check("rvalid_onehot", {31'd0, bus.m0_rvalid & bus.m1_rvalid}, 32'd0);
      if (sbq.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("rvalid_owner", {31'd0, bus.m1_rvalid}, {31'd0, e.id});
        check("rdata", e.id ? bus.m1_rdata : bus.m0_rdata, e.rdata);
        check("err", {31'd0, e.id ? bus.m1_err : bus.m0_err}, {31'd0, e.err});
      end
    end
  end

  task automatic drive(input bit id, input bit req, input bit we, input logic [1:0] size,
                       input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (!id) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_size = size;
      bus.m0_uns = uns; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_size = size;
      bus.m1_uns = uns; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   {30'd0, bus.m0_gnt, bus.m1_gnt}, 32'd0);
    check({tag, "_rv"},    {30'd0, bus.m0_rvalid, bus.m1_rvalid}, 32'd0);
    check({tag, "_err"},   {30'd0, bus.m0_err, bus.m1_err}, 32'd0);
    check({tag, "_rd0"},   bus.m0_rdata, 32'd0);
    check({tag, "_rd1"},   bus.m1_rdata, 32'd0);
    check({tag, "_mem"},   {26'd0, bus.mem_en, bus.mem_we, bus.mem_be}, 32'd0);
    check({tag, "_maddr"}, bus.mem_addr, 32'd0);
    check({tag, "_mwd"},   bus.mem_wdata, 32'd0);
  endtask

  task automatic do_txn(input bit id, input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bit got;
    bit e;
    logic [31:0] rexp;
    @(posedge clk); #1;
    drive(id, 1'b1, we, size, uns, addr, wdata);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? bus.m1_gnt : bus.m0_gnt) begin got = 1'b1; break; end
    end
    check("gnt_seen", {31'd0, got}, 32'd1);
    if (!got) begin
      drive(id, 1'b0, we, size, uns, addr, wdata);
      return;
    end
    check("gnt_other", {31'd0, id ? bus.m0_gnt : bus.m1_gnt}, 32'd0);
    check("mem_en_idle", {31'd0, bus.mem_en}, 32'd0);
    e = exp_err(size, addr);
    push_exp(id, we, size, uns, addr, wdata);
    rexp = sbq[$].rdata;
    @(posedge clk); #1;
    drive(id, 1'b0, we, size, uns, addr, wdata);
    @(negedge clk);
    check("mem_en", {31'd0, bus.mem_en}, {31'd0, !e});
    check("mem_we", {31'd0, bus.mem_we}, {31'd0, we && !e});
    check("gnt_access", {30'd0, bus.m0_gnt, bus.m1_gnt}, 32'd0);
    if (!e) begin
      check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
      check("mem_be", {28'd0, bus.mem_be}, we ? {28'd0, exp_be(size, addr[1:0])} : 32'd0);
      if (we) check("mem_wdata", bus.mem_wdata, exp_wd(size, wdata));
    end
    @(negedge clk);
    check("rvalid_t2", {31'd0, id ? bus.m1_rvalid : bus.m0_rvalid}, 32'd1);
    check("mem_en_resp", {31'd0, bus.mem_en}, 32'd0);
    @(negedge clk);
    check("rvalid_drop", {30'd0, bus.m0_rvalid, bus.m1_rvalid}, 32'd0);
    check("rdata_hold", id ? bus.m1_rdata : bus.m0_rdata, rexp);
  endtask

  task automatic contention(input int ngrants);
    int n, cyc, last;
    bit exp_id, g0, g1;
    n = 0; cyc = 0; last = 0; exp_id = 1'b0;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    drive(1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h46, 32'h0);
    while (n < ngrants && cyc < 80) begin
      @(negedge clk);
      cyc++;
      g0 = bus.m0_gnt;
      g1 = bus.m1_gnt;
      if (g0 && g1) check("gnt_both", 32'd1, 32'd0);
      if (g0 || g1) begin
        check("rr_order", {31'd0, g1}, {31'd0, exp_id});
        if (n > 0) check("gnt_gap", cyc - last, 32'd3);
        last = cyc;
        if (g1) push_exp(1, 1'b0, 2'b01, 1'b0, 32'h46, 32'h0);
        else    push_exp(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        exp_id = ~g1;
        n++;
        if (n == ngrants) begin
          @(posedge clk); #1;
          bus.m0_req = 1'b0;
          bus.m1_req = 1'b0;
        end
      end
    end
    check("rr_count", n, ngrants);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit got, seen;
    for (int unsigned i = 0; i < 256; i++) refm[i] = pat(i);
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    contention(6);

    do_txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    do_txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    do_txn(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
    do_txn(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    do_txn(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    do_txn(1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    do_txn(1, 1'b1, 2'b01, 1'b0, 32'h16, 32'h00008001);
    do_txn(1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    do_txn(1, 1'b0, 2'b01, 1'b1, 32'h16, 32'h0);

    do_txn(0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h1234);
    do_txn(0, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    do_txn(1, 1'b0, 2'b11, 1'b0, 32'h30, 32'h0);
    do_txn(0, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);

    // m1 store interrupted by reset while in ACCESS
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.m1_gnt) begin got = 1'b1; break; end
    end
    check("rst_gnt_m1", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    bus.m1_req = 1'b0;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    bus.m0_req = 1'b0;
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 256; i++) refm[i] = pat(i);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.m0_rvalid || bus.m1_rvalid) seen = 1'b1;
    end
    check("rst_no_rvalid", {31'd0, seen}, 32'd0);
    contention(2);

    repeat (4) @(negedge clk);
    check("sb_drain", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
